// File: rtl/spi_sck_gen.sv
// SPI serial clock burst generator: runtime half-period, CPOL/CPHA modes,
// bounded bursts with start/busy/done handshake, abort, and mode-resolved strobes.
module spi_sck_gen #(
  parameter int CNT_W  = 16,
  parameter int BITS_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [BITS_W-1:0] bit_count,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic              sample_stb,
  output logic              shift_stb,
  output logic [1:0]        o_state
);

  // Handshake: start is taken only while IDLE (state observable on o_state);
  // busy stays high from the cycle after the accept through the done cycle,
  // and done is a single-cycle pulse. start while busy is dropped, not queued.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH_A = 2'd1,
    S_PH_B = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_half;
  logic [CNT_W-1:0]    r_cnt;
  logic [BITS_W-1:0]   r_bits;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_busy;
  logic                r_done;
  logic                r_sck;
  logic                r_lead;
  logic                r_trail;
  logic                r_sample;
  logic                r_shift;
  logic                w_phase_end;

  // Phase counter runs 1..H, so it never exceeds r_half and cannot wrap.
  assign w_phase_end = (r_cnt == r_half);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_half   <= '0;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sck    <= 1'b0;
      r_lead   <= 1'b0;
      r_trail  <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_lead   <= 1'b0;
      r_trail  <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_sck   <= r_cpol;
        r_cnt   <= '0;
        r_bits  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_half <= (half_period == '0) ? CNT_W'(1) : half_period;
              r_bits <= bit_count;
              r_cpol <= cpol;
              r_cpha <= cpha;
              r_busy <= 1'b1;
              if (bit_count == '0) begin
                // Empty burst: straight to completion, SCK left untouched.
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_state <= S_PH_A;
                r_sck   <= cpol;
                r_cnt   <= CNT_W'(1);
              end
            end else begin
              r_sck <= cpol;
            end
          end
          S_PH_A: begin
            if (w_phase_end) begin
              r_state  <= S_PH_B;
              r_cnt    <= CNT_W'(1);
              r_sck    <= ~r_cpol;
              r_lead   <= 1'b1;
              r_sample <= ~r_cpha;
              r_shift  <= r_cpha;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_PH_B: begin
            if (w_phase_end) begin
              r_sck    <= r_cpol;
              r_trail  <= 1'b1;
              r_sample <= r_cpha;
              r_shift  <= ~r_cpha;
              r_bits   <= r_bits - 1'b1;
              if (r_bits == BITS_W'(1)) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_state <= S_PH_A;
                r_cnt   <= CNT_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sck   <= r_cpol;
            r_cnt   <= '0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sck        = r_sck;
  assign lead_edge  = r_lead;
  assign trail_edge = r_trail;
  assign sample_stb = r_sample;
  assign shift_stb  = r_shift;
  assign o_state    = r_state;

endmodule

// File: tb/tb_spi_sck_gen.sv
// Bench for spi_sck_gen: directed scenarios plus random traffic, compared each
// cycle against a timeline model computed from burst offset arithmetic.
module tb_spi_sck_gen;
  localparam int CNT_W  = 16;
  localparam int BITS_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  half_period = '0;
  logic [BITS_W-1:0] bit_count = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              busy, done, sck, lead_edge, trail_edge, sample_stb, shift_stb;
  logic [1:0]        o_state;

  spi_sck_gen #(.CNT_W(CNT_W), .BITS_W(BITS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .half_period(half_period), .bit_count(bit_count), .cpol(cpol), .cpha(cpha),
    .busy(busy), .done(done), .sck(sck), .lead_edge(lead_edge),
    .trail_edge(trail_edge), .sample_stb(sample_stb), .shift_stb(shift_stb),
    .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: burst described by accept offset k, H, N and latched mode
  bit m_active = 1'b0;
  int m_k = 0, m_H = 1, m_N = 0;
  bit m_cpol = 1'b0, m_cpha = 1'b0;
  bit e_busy = 0, e_done = 0, e_sck = 0, e_lead = 0, e_trail = 0, e_sample = 0, e_shift = 0;
  logic [BITS_W-1:0] exp_q[$];
  int obs_lead = 0, obs_trail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output at burst offset k (k >= 1, N > 0).
  task automatic burst_out();
    int p;
    bit first;
    if (m_k == 2 * m_N * m_H + 1) begin
      e_sck = m_cpol; e_trail = 1'b1; e_done = 1'b1;
    end else begin
      p     = (m_k - 1) / m_H;
      first = ((m_k - 1) % m_H) == 0;
      e_sck   = (p % 2 == 1) ? ~m_cpol : m_cpol;
      e_lead  = first && (p % 2 == 1);
      e_trail = first && (p % 2 == 0) && (p > 0);
    end
    e_busy = 1'b1;
  endtask

  task automatic model_step(input bit s, input bit a, input int hp, input int bc,
                            input bit pol, input bit pha);
    int end_k;
    e_done = 0; e_lead = 0; e_trail = 0;
    if (m_active) begin
      end_k = (m_N == 0) ? 1 : 2 * m_N * m_H + 1;
      if (a || m_k == end_k) begin
        if (m_k != end_k) void'(exp_q.pop_back());
        m_active = 1'b0; e_busy = 1'b0; e_sck = m_cpol;
      end else begin
        m_k++;
        burst_out();
      end
    end else if (s) begin
      m_active = 1'b1; m_k = 1;
      m_H = (hp == 0) ? 1 : hp; m_N = bc; m_cpol = pol; m_cpha = pha;
      exp_q.push_back(BITS_W'(bc));
      obs_lead = 0; obs_trail = 0;
      e_busy = 1'b1;
      if (m_N == 0) e_done = 1'b1;
      else burst_out();
    end else begin
      e_busy = 1'b0; e_sck = pol;
    end
    e_sample = m_cpha ? e_trail : e_lead;
    e_shift  = m_cpha ? e_lead : e_trail;
  endtask

  // scoreboard: per-cycle outputs plus per-burst edge totals
  task automatic check_cycle();
    logic [6:0] got, exp;
    logic [BITS_W-1:0] n;
    got = {busy, done, sck, lead_edge, trail_edge, sample_stb, shift_stb};
    exp = {e_busy, e_done, e_sck, e_lead, e_trail, e_sample, e_shift};
    check("outs", 32'(got), 32'(exp));
    obs_lead  += int'(lead_edge);
    obs_trail += int'(trail_edge);
    if (done === 1'b1) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        n = exp_q.pop_front();
        check("lead_cnt", 32'(obs_lead), 32'(n));
        check("trail_cnt", 32'(obs_trail), 32'(n));
      end
    end
  endtask

  // driver: apply inputs at posedge+1, advance model, check after next edge
  task automatic cycle(input bit s, input bit a, input int hp, input int bc,
                       input bit pol, input bit pha);
    start = s; abort = a; half_period = hp[CNT_W-1:0]; bit_count = bc[BITS_W-1:0];
    cpol = pol; cpha = pha;
    model_step(s, a, hp, bc, pol, pha);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n, input bit pol);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, pol, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'({busy, done, sck, lead_edge, trail_edge, sample_stb, shift_stb}), 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // mode 0, H=2, N=3
    cycle(1, 0, 2, 3, 0, 0);
    idle(16, 1'b0);

    // mode 3, half_period 0 treated as 1, N=4
    idle(2, 1'b1);
    cycle(1, 0, 0, 4, 1, 1);
    idle(12, 1'b1);

    // empty burst
    cycle(1, 0, 5, 0, 1, 0);
    idle(4, 1'b1);

    // start held high across bursts, changing inputs mid-burst
    for (int i = 0; i < 40; i++) cycle(1, 0, (i < 10) ? 1 : 3, 2, i > 5, 0);
    idle(20, 1'b0);
    cycle(1, 0, 2, 3, 0, 0);
    for (int i = 0; i < 20; i++) cycle((i % 3) == 0, 0, 7, 1, i[0], 1);
    idle(30, 1'b0);

    // abort during the second PH_B (H=3, N=5), then a fresh burst
    cycle(1, 0, 3, 5, 0, 1);
    idle(10, 1'b0);
    cycle(0, 1, 0, 0, 0, 0);
    idle(3, 1'b0);
    cycle(1, 0, 3, 5, 0, 1);
    idle(35, 1'b0);

    // longest burst and a long half-period
    cycle(1, 0, 1, 63, 0, 0);
    idle(130, 1'b0);
    cycle(1, 0, 1000, 1, 1, 1);
    idle(2005, 1'b1);

    // asynchronous reset mid-burst
    cycle(1, 0, 4, 6, 1, 0);
    idle(7, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({busy, done, sck, lead_edge, trail_edge, sample_stb, shift_stb}), 32'd0);
    m_active = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
    exp_q.delete();
    e_busy = 0; e_done = 0; e_sck = 0; e_lead = 0; e_trail = 0; e_sample = 0; e_shift = 0;
    @(posedge clk);
    #1;
    check("rst_hold", 32'({busy, done, sck, lead_edge, trail_edge, sample_stb, shift_stb}), 32'd0);
    rst_n = 1'b1;
    idle(10, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
            int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(100, 1'b0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
